// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS constants, instruction field positions and opcodes
package mips_pkg;
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int JADDR_HI = 25;
    localparam int JADDR_LO = 0;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_RTYPE = 6'h00;
endpackage

// File: rtl/ins_predecode.sv
// ins_predecode: combinational split of a MIPS instruction into its fields
module ins_predecode
    import mips_pkg::*;
(
    input  logic [31:0] ins,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [31:0] imm_sext,
    output logic [25:0] jaddr
);
    assign opcode   = ins[OP_HI:OP_LO];
    assign rs       = ins[RS_HI:RS_LO];
    assign rt       = ins[RT_HI:RT_LO];
    assign rd       = ins[RD_HI:RD_LO];
    assign shamt    = ins[SHAMT_HI:SHAMT_LO];
    assign funct    = ins[FUNCT_HI:FUNCT_LO];
    // branch-offset <<2 is left to the consumer
    assign imm_sext = {{16{ins[IMM_HI]}}, ins[IMM_HI:IMM_LO]};
    assign jaddr    = ins[JADDR_HI:JADDR_LO];
endmodule

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with stall, flush, predecode and perf counters
module if_id_reg
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      NEXT_INS_ADR_IN,
    input  logic [31:0]      CUR_INS_IN,
    input  logic             STALL,
    input  logic             FLUSH,
    output logic [31:0]      NEXT_INS_ADR,
    output logic [31:0]      CUR_INS,
    output logic             VALID,
    output logic [5:0]       OPCODE,
    output logic [4:0]       RS,
    output logic [4:0]       RT,
    output logic [4:0]       RD,
    output logic [4:0]       SHAMT,
    output logic [5:0]       FUNCT,
    output logic [31:0]      IMM_SEXT,
    output logic [25:0]      JADDR,
    output logic [CNT_W-1:0] CNT_FETCH,
    output logic [CNT_W-1:0] CNT_STALL,
    output logic [CNT_W-1:0] CNT_FLUSH
);
    always_ff @(posedge CLK) begin
        if (RST) begin
            NEXT_INS_ADR <= '0;
            CUR_INS      <= NOP;
            VALID        <= 1'b0;
            CNT_FETCH    <= '0;
            CNT_STALL    <= '0;
            CNT_FLUSH    <= '0;
        end else if (FLUSH) begin
            NEXT_INS_ADR <= '0;
            CUR_INS      <= NOP;
            VALID        <= 1'b0;
            CNT_FLUSH    <= CNT_FLUSH + CNT_W'(1);
        end else if (STALL) begin
            CNT_STALL    <= CNT_STALL + CNT_W'(1);
        end else begin
            NEXT_INS_ADR <= NEXT_INS_ADR_IN;
            CUR_INS      <= CUR_INS_IN;
            VALID        <= 1'b1;
            CNT_FETCH    <= CNT_FETCH + CNT_W'(1);
        end
    end

    // decode from the register so fields can never lag CUR_INS
    ins_predecode u_dec (
        .ins      (CUR_INS),
        .opcode   (OPCODE),
        .rs       (RS),
        .rt       (RT),
        .rd       (RD),
        .shamt    (SHAMT),
        .funct    (FUNCT),
        .imm_sext (IMM_SEXT),
        .jaddr    (JADDR)
    );
endmodule

// File: tb/tb_if_id_reg.sv
// tb_if_id_reg: directed self-checking bench for if_id_reg
module tb_if_id_reg;
    import mips_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr_in = '0, ins_in = '0;
    logic        stall = 1'b0, flush = 1'b0;
    logic [31:0] next_adr, cur_ins, imm_sext;
    logic        valid;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [25:0] jaddr;
    logic [31:0] cnt_fetch, cnt_stall, cnt_flush;
    logic [31:0] w_adr, w_ins, w_imm;
    logic        w_valid;
    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs, w_rt, w_rd, w_sh;
    logic [25:0] w_ja;
    logic [3:0]  w_fetch, w_stall, w_flush;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    if_id_reg #(.CNT_W(32)) dut (
        .CLK(clk), .RST(rst), .NEXT_INS_ADR_IN(adr_in), .CUR_INS_IN(ins_in),
        .STALL(stall), .FLUSH(flush), .NEXT_INS_ADR(next_adr), .CUR_INS(cur_ins),
        .VALID(valid), .OPCODE(opcode), .RS(rs), .RT(rt), .RD(rd), .SHAMT(shamt),
        .FUNCT(funct), .IMM_SEXT(imm_sext), .JADDR(jaddr),
        .CNT_FETCH(cnt_fetch), .CNT_STALL(cnt_stall), .CNT_FLUSH(cnt_flush)
    );

    if_id_reg #(.CNT_W(4)) dut4 (
        .CLK(clk), .RST(rst), .NEXT_INS_ADR_IN(adr_in), .CUR_INS_IN(ins_in),
        .STALL(stall), .FLUSH(flush), .NEXT_INS_ADR(w_adr), .CUR_INS(w_ins),
        .VALID(w_valid), .OPCODE(w_op), .RS(w_rs), .RT(w_rt), .RD(w_rd), .SHAMT(w_sh),
        .FUNCT(w_fn), .IMM_SEXT(w_imm), .JADDR(w_ja),
        .CNT_FETCH(w_fetch), .CNT_STALL(w_stall), .CNT_FLUSH(w_flush)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            adr_in = $urandom; ins_in = $urandom; stall = 1'(i); flush = 1'b0;
            tick();
        end
        total++; if (cur_ins !== 32'h0) begin bad++; $display("FAIL reset_ins got=%h exp=0", cur_ins); end
        total++; if (next_adr !== 32'h0) begin bad++; $display("FAIL reset_adr got=%h exp=0", next_adr); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
        total++; if ({opcode, rs, rt, rd, shamt, funct, imm_sext, jaddr} !== '0) begin bad++; $display("FAIL reset_fields got=%h exp=0", {opcode, rs, rt, rd, shamt, funct, imm_sext, jaddr}); end
        total++; if ({cnt_fetch, cnt_stall, cnt_flush} !== '0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", {cnt_fetch, cnt_stall, cnt_flush}); end
        total++; if ({w_fetch, w_stall, w_flush} !== '0) begin bad++; $display("FAIL reset_cnt4 got=%h exp=0", {w_fetch, w_stall, w_flush}); end
        rst = 1'b0; stall = 1'b0;
    endtask

    task automatic test_load();
        adr_in = 32'h4; ins_in = 32'h8C22_0010;
        tick();
        total++; if (next_adr !== 32'h4) begin bad++; $display("FAIL load_adr got=%h exp=4", next_adr); end
        total++; if (cur_ins !== 32'h8C22_0010) begin bad++; $display("FAIL load_ins got=%h exp=8c220010", cur_ins); end
        total++; if (opcode !== OP_LW) begin bad++; $display("FAIL load_op got=%h exp=23", opcode); end
        total++; if (rs !== 5'd1 || rt !== 5'd2) begin bad++; $display("FAIL load_rs_rt got=%0d,%0d exp=1,2", rs, rt); end
        total++; if (imm_sext !== 32'h10) begin bad++; $display("FAIL load_imm got=%h exp=10", imm_sext); end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL load_valid got=%b exp=1", valid); end
        total++; if (cnt_fetch !== 32'd1) begin bad++; $display("FAIL load_cnt got=%0d exp=1", cnt_fetch); end
    endtask

    task automatic test_sign_extend();
        adr_in = 32'h8; ins_in = 32'h1062_FFFC;
        tick();
        total++; if (opcode !== OP_BEQ) begin bad++; $display("FAIL beq_op got=%h exp=04", opcode); end
        total++; if (rs !== 5'd3 || rt !== 5'd2) begin bad++; $display("FAIL beq_rs_rt got=%0d,%0d exp=3,2", rs, rt); end
        total++; if (imm_sext !== 32'hFFFF_FFFC) begin bad++; $display("FAIL beq_imm got=%h exp=fffffffc", imm_sext); end
        adr_in = 32'hC; ins_in = 32'h0800_0040;
        tick();
        total++; if (opcode !== OP_J) begin bad++; $display("FAIL j_op got=%h exp=02", opcode); end
        total++; if (jaddr !== 26'h40) begin bad++; $display("FAIL j_addr got=%h exp=0000040", jaddr); end
        total++; if (cnt_fetch !== 32'd3) begin bad++; $display("FAIL sext_cnt got=%0d exp=3", cnt_fetch); end
    endtask

    task automatic test_stall();
        adr_in = 32'h10; ins_in = 32'h0022_1820;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adr_in = 32'h100 + 32'(i); ins_in = 32'hDEAD_0000 + 32'(i);
            tick();
            total++; if (cur_ins !== 32'h0022_1820 || next_adr !== 32'h10 || valid !== 1'b1) begin bad++; $display("FAIL stall_hold got=%h/%h/%b exp=00221820/10/1", cur_ins, next_adr, valid); end
            total++; if (opcode !== OP_RTYPE || rd !== 5'd3 || funct !== 6'h20) begin bad++; $display("FAIL stall_fields got=%h/%0d/%h exp=00/3/20", opcode, rd, funct); end
        end
        total++; if (cnt_stall !== 32'd3 || cnt_fetch !== 32'd4) begin bad++; $display("FAIL stall_cnt got=%0d/%0d exp=3/4", cnt_stall, cnt_fetch); end
        stall = 1'b0; adr_in = 32'h14; ins_in = 32'h8C43_0008;
        tick();
        total++; if (cur_ins !== 32'h8C43_0008 || next_adr !== 32'h14) begin bad++; $display("FAIL stall_release got=%h/%h exp=8c430008/14", cur_ins, next_adr); end
        total++; if (cnt_fetch !== 32'd5 || cnt_stall !== 32'd3) begin bad++; $display("FAIL release_cnt got=%0d/%0d exp=5/3", cnt_fetch, cnt_stall); end
    endtask

    task automatic test_flush();
        flush = 1'b1; stall = 1'b1; adr_in = 32'h18; ins_in = 32'h1062_FFFC;
        tick();
        total++; if (cur_ins !== NOP || valid !== 1'b0 || next_adr !== 32'h0) begin bad++; $display("FAIL flush_out got=%h/%b/%h exp=0/0/0", cur_ins, valid, next_adr); end
        total++; if (rs !== 5'd0 || rt !== 5'd0 || imm_sext !== 32'h0) begin bad++; $display("FAIL flush_fields got=%0d/%0d/%h exp=0/0/0", rs, rt, imm_sext); end
        total++; if (cnt_flush !== 32'd1 || cnt_stall !== 32'd3 || cnt_fetch !== 32'd5) begin bad++; $display("FAIL flush_cnt got=%0d/%0d/%0d exp=1/3/5", cnt_flush, cnt_stall, cnt_fetch); end
        flush = 1'b0;
        tick();
        total++; if (cnt_stall !== 32'd4 || valid !== 1'b0) begin bad++; $display("FAIL bubble_stall got=%0d/%b exp=4/0", cnt_stall, valid); end
        rst = 1'b1;
        tick();
        total++; if ({cnt_fetch, cnt_stall, cnt_flush} !== '0 || cur_ins !== NOP || valid !== 1'b0) begin bad++; $display("FAIL rst_in_stall got=%0d/%0d/%0d/%h/%b exp=0", cnt_fetch, cnt_stall, cnt_flush, cur_ins, valid); end
        rst = 1'b0; stall = 1'b0;
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            adr_in = 32'(4 * (i + 1)); ins_in = 32'h8C22_0000 + 32'(i);
            tick();
        end
        total++; if (w_fetch !== 4'd1) begin bad++; $display("FAIL wrap_fetch got=%0d exp=1", w_fetch); end
        total++; if (w_stall !== 4'd0 || w_flush !== 4'd0) begin bad++; $display("FAIL wrap_others got=%0d/%0d exp=0/0", w_stall, w_flush); end
        total++; if (cnt_fetch !== 32'd17) begin bad++; $display("FAIL wrap_wide got=%0d exp=17", cnt_fetch); end
        total++; if (w_ins !== 32'h8C22_0010 || w_adr !== 32'h44) begin bad++; $display("FAIL wrap_data got=%h/%h exp=8c220010/44", w_ins, w_adr); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_sign_extend();
        test_stall();
        test_flush();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_id_reg.md
# if_id_reg

IF/ID pipeline register of the MIPS datapath. Sits directly downstream of the fetch-select stage. Captures the fetched instruction and its PC+4 every cycle, and pre-decodes the instruction into registered MIPS fields for the ID stage. Supports hazard stall (hold) and control-hazard flush (bubble insertion), and keeps free-running performance counters for fetches, stall cycles and flushes.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- CLK  input  1  single clock; all state updates on its rising edge.
- RST  input  1  reset; synchronous and active-high.
- NEXT_INS_ADR_IN  input  32  PC+4 from the fetch-select stage.
- CUR_INS_IN  input  32  fetched instruction from the fetch-select stage.
- STALL  input  1  hold request from the hazard unit.
- FLUSH  input  1  bubble request from branch/jump resolution.
- NEXT_INS_ADR  output  32  registered PC+4.
- CUR_INS  output  32  registered instruction.
- VALID  output  1  1 = CUR_INS is a real fetched instruction; 0 = bubble.
- OPCODE  output  6  CUR_INS[31:26].
- RS  output  5  CUR_INS[25:21].
- RT  output  5  CUR_INS[20:16].
- RD  output  5  CUR_INS[15:11].
- SHAMT  output  5  CUR_INS[10:6].
- FUNCT  output  6  CUR_INS[5:0].
- IMM_SEXT  output  32  CUR_INS[15:0] sign-extended to 32 bits.
- JADDR  output  26  CUR_INS[25:0].
- CNT_FETCH  output  CNT_W  number of load cycles.
- CNT_STALL  output  CNT_W  number of effective stall cycles.
- CNT_FLUSH  output  CNT_W  number of flush cycles.

## Operation
- Per-edge action, in priority order: RST, FLUSH, STALL, LOAD (default).
- RST: all outputs and counters go to 0. VALID=0. CUR_INS=NOP (0x00000000).
- FLUSH: CUR_INS=NOP, NEXT_INS_ADR=0, VALID=0, all decoded fields 0. CNT_FLUSH+1. Inputs are discarded.
- STALL (FLUSH=0): every data output holds its value, including VALID. CNT_STALL+1. Inputs are discarded; the upstream stage is responsible for re-presenting the same instruction.
- LOAD: capture NEXT_INS_ADR_IN and CUR_INS_IN. VALID=1. Decoded fields come from the newly captured instruction. CNT_FETCH+1.
- FLUSH and STALL in the same cycle: the flush wins. Only CNT_FLUSH increments.
- Decoded fields are a pure function of the CUR_INS register. They are never stale relative to CUR_INS, including after a flush (NOP decodes to all zeros).
- IMM_SEXT: bits [31:16] replicate CUR_INS[15]. No shift is applied; the branch-offset <<2 is done downstream.
- Counters are unsigned and wrap modulo 2^CNT_W with no saturation. They are cleared only by RST.
- RST asserted during a stall or flush sequence takes effect on the next edge and overrides both.
- No internal FSM is needed beyond the priority mux. There is no multi-cycle state.

## Timing
- Latency: 1 cycle from input to CUR_INS/NEXT_INS_ADR/fields/VALID.
- The upstream fetch stage is combinational, so inputs must be stable before the rising edge of CLK; no input is sampled off-edge.
- STALL and FLUSH are sampled on the same edge as the data.
  - A stall asserted in cycle n freezes the outputs seen in cycle n+1.
  - A flush in cycle n shows a bubble in cycle n+1.
- Counter updates occur on the same edge as the action they count. Counter values are visible the following cycle.
- The first edge after RST deasserts performs a normal LOAD, unless FLUSH or STALL is asserted.

## Structure
- Shared package mips_pkg:
  - NOP constant (32'h00000000).
  - Instruction field bit positions.
  - Opcode constants used by the bench (LW=6'h23, BEQ=6'h04, J=6'h02, RTYPE=6'h00).
- One sub-module, ins_predecode: combinational field split plus sign-extension. It is instantiated on the CUR_INS register output and is reusable by later stages.
- Counters live in the top level as three independent registers.

## Test plan
- Reset: hold RST=1 for 2 cycles with random inputs -> CUR_INS=0, NEXT_INS_ADR=0, VALID=0, all fields 0, all counters 0.
- Load: NEXT_INS_ADR_IN=0x4, CUR_INS_IN=0x8C220010 (lw $2,16($1)) -> next cycle NEXT_INS_ADR=0x4, OPCODE=0x23, RS=1, RT=2, IMM_SEXT=0x00000010, VALID=1, CNT_FETCH=1.
- Sign-extend: CUR_INS_IN=0x1062FFFC (beq $3,$2,-4) -> OPCODE=0x04, RS=3, RT=2, IMM_SEXT=0xFFFFFFFC. Also CUR_INS_IN=0x08000040 (j) -> JADDR=0x0000040.
- Stall: after a load, hold STALL=1 for 3 cycles while the inputs change every cycle -> outputs unchanged throughout, CNT_STALL=3, CNT_FETCH unchanged. Release -> the new input is captured.
- Flush priority: FLUSH=1 and STALL=1 together with a valid instruction held -> next cycle CUR_INS=0, VALID=0, RS=RT=0, CNT_FLUSH+1, CNT_STALL unchanged. Then assert RST during an active stall -> all outputs and counters return to 0.
- Wrap: with CNT_W=4, apply 17 consecutive loads -> CNT_FETCH=1, with the other counters still 0.
